// File: rtl/zbt_video_reader.sv
// zbt_video_reader: VGA raster timing generator that streams pixels out of a
// double-buffered ZBT SRAM. It issues one read address per active pixel,
// realigns the returned data with delayed sync/blank flags, and flips the
// display bank at frame boundaries on the writer's request.
module zbt_video_reader #(
    parameter int READ_LATENCY = 2,
    parameter int H_ACTIVE     = 800,
    parameter int H_FP         = 40,
    parameter int H_SYNC       = 128,
    parameter int H_BP         = 88,
    parameter int V_ACTIVE     = 600,
    parameter int V_FP         = 1,
    parameter int V_SYNC       = 4,
    parameter int V_BP         = 23
) (
    input  logic        internal_clock_40,
    input  logic        resetn,
    output logic [18:0] Video_Address_40_O,
    input  logic [31:0] Video_Data_40_I,
    input  logic        Swap_Request_I,
    output logic        Swap_Ack_O,
    output logic        Bank_Select_O,
    output logic        Frame_Start_O,
    output logic [7:0]  VGA_Red_O,
    output logic [7:0]  VGA_Green_O,
    output logic [7:0]  VGA_Blue_O,
    output logic        VGA_HSync_O,
    output logic        VGA_VSync_O,
    output logic        VGA_Blank_n_O
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W      = $clog2(H_TOTAL + 1);
    localparam int V_W      = $clog2(V_TOTAL + 1);
    // Flags must cover one address-register cycle, the SRAM latency and the
    // RGB output register.
    localparam int DL       = READ_LATENCY + 2;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;
    logic [18:0]    pix_q, pix_d;
    logic [18:0]    addr_q, addr_d;
    logic           bank_q, bank_d;
    logic           ack_q, ack_d;
    logic [DL-1:0]  act_dl_q, act_dl_d;
    logic [DL-1:0]  hs_dl_q, hs_dl_d;
    logic [DL-1:0]  vs_dl_q, vs_dl_d;
    logic [23:0]    rgb_q, rgb_d;

    logic active;
    logic hs_raw;
    logic vs_raw;
    logic last_cycle;
    logic swap_now;
    logic unused_data_bits;

    // Decode raster position into active/sync flags and the frame-end strobe.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
        active     = (h_q < H_W'(H_ACTIVE)) && (v_q < V_W'(V_ACTIVE));
        hs_raw     = (h_q >= H_W'(HS_START)) && (h_q < H_W'(HS_END));
        vs_raw     = (v_q >= V_W'(VS_START)) && (v_q < V_W'(VS_END));
        last_cycle = (h_q == H_W'(H_TOTAL - 1)) && (v_q == V_W'(V_TOTAL - 1));
        swap_now   = last_cycle && Swap_Request_I;
    end

    // Next-state: raster counters, pixel address, bank swap, flag delay lines, RGB.
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_W'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == V_W'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
        end

        // Running pixel index replaces v*H_ACTIVE+h without a multiplier.
        pix_d = pix_q;
        if (last_cycle) begin
            pix_d = '0;
        end else if (active) begin
            pix_d = pix_q + 19'd1;
        end

        // Address register only moves on active pixels, holding through blanking.
        addr_d = active ? pix_q : addr_q;

        // Swap is only honoured at the frame boundary, so at most once per frame.
        ack_d  = swap_now;
        bank_d = bank_q ^ swap_now;

        act_dl_d = {act_dl_q[DL-2:0], active};
        hs_dl_d  = {hs_dl_q[DL-2:0], hs_raw};
        vs_dl_d  = {vs_dl_q[DL-2:0], vs_raw};

        // Data arriving now belongs to the pixel whose flag sits one stage
        // short of the output end of the delay line.
        rgb_d = act_dl_q[READ_LATENCY] ? Video_Data_40_I[23:0] : 24'd0;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge internal_clock_40) begin
        // NOTE: non-blocking assignments, so every flop sees pre-edge values of the others.
        if (!resetn) begin
            h_q      <= '0;
            v_q      <= '0;
            pix_q    <= '0;
            addr_q   <= '0;
            bank_q   <= 1'b0;
            ack_q    <= 1'b0;
            // NOTE: the delay lines are plain flops, not a RAM, so they can and do reset here.
            act_dl_q <= '0;
            hs_dl_q  <= '0;
            vs_dl_q  <= '0;
            rgb_q    <= '0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            pix_q    <= pix_d;
            addr_q   <= addr_d;
            bank_q   <= bank_d;
            ack_q    <= ack_d;
            act_dl_q <= act_dl_d;
            hs_dl_q  <= hs_dl_d;
            vs_dl_q  <= vs_dl_d;
            rgb_q    <= rgb_d;
        end
    end

    // Byte [31:24] of the SRAM word carries no colour.
    assign unused_data_bits = ^Video_Data_40_I[31:24];

    assign Video_Address_40_O = addr_q;
    assign Swap_Ack_O         = ack_q;
    assign Bank_Select_O      = bank_q;
    // Gated with resetn so the pulse is absent while reset is held and
    // present in the first cycle after release, when counters sit at (0,0).
    assign Frame_Start_O      = resetn && (h_q == '0) && (v_q == '0);
    assign VGA_Red_O          = rgb_q[23:16];
    assign VGA_Green_O        = rgb_q[15:8];
    assign VGA_Blue_O         = rgb_q[7:0];
    assign VGA_HSync_O        = hs_dl_q[DL-1];
    assign VGA_VSync_O        = vs_dl_q[DL-1];
    assign VGA_Blank_n_O      = act_dl_q[DL-1];

endmodule

// File: tb/tb_zbt_video_reader.sv
// tb_zbt_video_reader: scoreboard bench with a reduced raster so several
// frames fit in a short run. A reference model derives every expected output
// from the number of cycles since reset; a monitor compares each cycle.
module tb_zbt_video_reader;

    localparam int L     = 2;
    localparam int HA    = 16;
    localparam int HFP   = 2;
    localparam int HS    = 4;
    localparam int HBP   = 3;
    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VA    = 8;
    localparam int VFP   = 1;
    localparam int VS    = 2;
    localparam int VBP   = 2;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int DL    = L + 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        swap_req = 1'b0;
    logic [31:0] vdata = '0;
    logic [18:0] vaddr;
    logic        swap_ack, bank_sel, frame_start;
    logic [7:0]  red, green, blue;
    logic        hsync, vsync, blank_n;

    typedef struct packed {
        logic [18:0] addr;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        fs;
        logic        bank;
        logic        ack;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    zbt_video_reader #(
        .READ_LATENCY(L),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .internal_clock_40 (clk),
        .resetn            (resetn),
        .Video_Address_40_O(vaddr),
        .Video_Data_40_I   (vdata),
        .Swap_Request_I    (swap_req),
        .Swap_Ack_O        (swap_ack),
        .Bank_Select_O     (bank_sel),
        .Frame_Start_O     (frame_start),
        .VGA_Red_O         (red),
        .VGA_Green_O       (green),
        .VGA_Blue_O        (blue),
        .VGA_HSync_O       (hsync),
        .VGA_VSync_O       (vsync),
        .VGA_Blank_n_O     (blank_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int cyc,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected outputs in the cycle that is k cycles after the last reset edge.
    function automatic exp_t model_out(input int k, input logic rst_now,
                                       input logic bank, input logic ack);
        exp_t e;
        int q, p, h, v;
        e       = '0;
        e.bank  = bank;
        e.ack   = ack;
        e.fs    = rst_now && ((k % FRAME) == 0);
        // Address shows the most recent active pixel of the previous cycle.
        if (k == 0) begin
            e.addr = '0;
        end else begin
            q = (k - 1) % FRAME;
            h = q % HT;
            v = q / HT;
            if (v >= VA)      e.addr = 19'(HA * VA - 1);
            else if (h >= HA) e.addr = 19'(v * HA + HA - 1);
            else              e.addr = 19'(v * HA + h);
        end
        // Display outputs show the raster position DL cycles ago, if it exists.
        if (k >= DL) begin
            p       = (k - DL) % FRAME;
            h       = p % HT;
            v       = p / HT;
            e.blank = (h < HA) && (v < VA);
            e.hs    = (h >= HA + HFP) && (h < HA + HFP + HS);
            e.vs    = (v >= VA + VFP) && (v < VA + VFP + VS);
            if (e.blank) e.rgb = 24'(v * HA + h);
        end
        return e;
    endfunction

    // ZBT model: data presented L cycles after its address, junk in [31:24].
    initial begin : zbt
        logic [18:0] hist [0:L];
        for (int i = 0; i <= L; i++) hist[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = L; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = vaddr;
            vdata   = {8'($urandom), 5'b0, hist[L]};
        end
    end

    // Reference model: pushes one expected record per clock edge.
    initial begin : model
        logic rst_s, swap_s, m_bank, m_ack;
        int   since;
        since  = 0;
        m_bank = 1'b0;
        m_ack  = 1'b0;
        forever begin
            @(posedge clk);
            rst_s  = resetn;
            swap_s = swap_req;
            #2;
            if (!rst_s) begin
                since  = 0;
                m_bank = 1'b0;
                m_ack  = 1'b0;
            end else begin
                m_ack  = ((since % FRAME) == FRAME - 1) && swap_s;
                m_bank = m_bank ^ m_ack;
                since++;
            end
            exp_q.push_back(model_out(since, resetn, m_bank, m_ack));
        end
    end

    // Monitor: pops one expectation per cycle and compares on the falling edge.
    initial begin : monitor
        exp_t e;
        int   cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty cycle %0d: got 0 entries required 1", cyc);
            end else begin
                e = exp_q.pop_front();
                check("address",   cyc, 32'(vaddr),                 32'(e.addr));
                check("rgb",       cyc, 32'({red, green, blue}),    32'(e.rgb));
                check("hsync",     cyc, 32'(hsync),                 32'(e.hs));
                check("vsync",     cyc, 32'(vsync),                 32'(e.vs));
                check("blank_n",   cyc, 32'(blank_n),               32'(e.blank));
                check("frame_start", cyc, 32'(frame_start),         32'(e.fs));
                check("bank_sel",  cyc, 32'(bank_sel),              32'(e.bank));
                check("swap_ack",  cyc, 32'(swap_ack),              32'(e.ack));
            end
            cyc++;
        end
    end

    // Scripted swap requests for the first frames after release, by cycle index.
    function automatic logic script_req(input int p);
        if (p >= 3 * HT + 10 && p < FRAME)  return 1'b1; // mid-frame raise, held to ack
        if (p == 3 * FRAME - 1)             return 1'b1; // raised in the last cycle only
        if (p >= 3 * FRAME && p < 6 * FRAME) return 1'b1; // raised at (0,0), held 3 frames
        return 1'b0;
    endfunction

    // Stimulus driver: inputs change 1 time unit after the active edge.
    initial begin : driver
        int rst_at;
        rst_at   = 6 * FRAME + 5 * HT + 10;
        resetn   = 1'b0;
        swap_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        for (int p = 0; p < rst_at; p++) begin
            swap_req = script_req(p);
            @(posedge clk);
            #1;
        end

        // Mid-frame reset for three edges with bank select at 1.
        resetn   = 1'b0;
        swap_req = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b1;

        // Randomised swap requests over two further frames.
        for (int p = 0; p < 2 * FRAME + 40; p++) begin
            swap_req = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end

        swap_req = 1'b0;
        repeat (DL + 2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
